// File: rtl/fifo_pkg.sv
// Shared constants, width helper and parameter-legality predicates for the
// synchronous FIFO and its storage array.
package fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AF_LEVEL = 14;
  localparam int DEF_AE_LEVEL = 2;

  // Accepted-operation encoding, indexed as {wr_acc, rd_acc}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

  // Minimum number of bits needed to address n entries (at least 1).
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = int'(i) + 1;
    end
    return w;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_ok(input int af, input int depth);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_ok(input int ae, input int depth);
    return (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port and one registered
// read port. No reset; contents and read register power up undefined.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = clog2w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port: store the incoming word at the write address.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port: capture the addressed word; hold it when not reading.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Synchronous FIFO controller: self-managed pointers and occupancy,
// status flags from the registered count, one-cycle registered read with a
// valid strobe, and sticky overflow/underflow flags.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int AF_LEVEL = DEF_AF_LEVEL,
  parameter  int AE_LEVEL = DEF_AE_LEVEL,
  localparam int ADDR_W   = clog2w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              en_write,
  input  logic              en_read,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_sync_ctrl: DEPTH must be a power of 2 and >= 2");
  end
  if (!af_ok(AF_LEVEL, DEPTH)) begin : g_bad_af
    $error("fifo_sync_ctrl: AF_LEVEL must be in 1..DEPTH");
  end
  if (!ae_ok(AE_LEVEL, DEPTH)) begin : g_bad_ae
    $error("fifo_sync_ctrl: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_sync_ctrl: WIDTH must be >= 1");
  end

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_L    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   AE_L    = (ADDR_W + 1)'(AE_LEVEL);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_valid;
  logic              r_has_data;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_mem_wr;
  logic              w_mem_rd;
  op_e               w_op;
  logic [ADDR_W:0]   w_count_nxt;
  logic [WIDTH-1:0]  w_mem_q;

  // Accept decisions from the pre-edge state; a full FIFO takes a write
  // only when a read frees a slot in the same cycle.
  always_comb begin
    w_empty  = (r_count == '0);
    w_full   = (r_count == CNT_MAX);
    w_rd_acc = en_read & ~w_empty;
    w_wr_acc = en_write & (~w_full | w_rd_acc);
    w_op     = op_e'({w_wr_acc, w_rd_acc});
    // Reset aborts any access to the array in the same cycle.
    w_mem_wr = w_wr_acc & reset;
    w_mem_rd = w_rd_acc & reset;
  end

  // Occupancy next-state from the accepted operation pair.
  always_comb begin
    w_count_nxt = r_count;
    case (w_op)
      OP_WR:   w_count_nxt = r_count + CNT_ONE;
      OP_RD:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, count, read-valid and sticky error state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_has_data  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_valid <= w_rd_acc;
      if (w_rd_acc) r_has_data <= 1'b1;
      // A new error in the same cycle as clr_err keeps the flag set.
      r_overflow  <= (en_write & ~w_wr_acc) | (r_overflow  & ~clr_err);
      r_underflow <= (en_read  & ~w_rd_acc) | (r_underflow & ~clr_err);
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk     (clk),
    .i_wr_en   (w_mem_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_en   (w_mem_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_q)
  );

  // The array's read register has no reset, so data_out reads as zero until
  // the first accepted read after reset; afterwards it follows that register,
  // which holds between reads.
  assign data_out     = r_has_data ? w_mem_q : '0;
  assign data_valid   = r_valid;
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= AF_L);
  assign almost_empty = (r_count <= AE_L);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed self-checking bench: default 8x16 instance plus a 32x4 instance.
module tb_fifo_sync_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default configuration instance
  logic        rst_a = 1'b0;
  logic [7:0]  din_a = '0;
  logic        wr_a = 1'b0, rd_a = 1'b0, clr_a = 1'b0;
  logic [7:0]  dout_a;
  logic        dv_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [4:0]  cnt_a;

  fifo_sync_ctrl u_dut_a (
    .clk(clk), .reset(rst_a), .data_in(din_a), .en_write(wr_a),
    .en_read(rd_a), .clr_err(clr_a), .data_out(dout_a), .data_valid(dv_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(cnt_a), .overflow(ovf_a),
    .underflow(udf_a)
  );

  // Swept configuration instance
  logic        rst_b = 1'b0;
  logic [31:0] din_b = '0;
  logic        wr_b = 1'b0, rd_b = 1'b0, clr_b = 1'b0;
  logic [31:0] dout_b;
  logic        dv_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [2:0]  cnt_b;

  fifo_sync_ctrl #(
    .WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .data_in(din_b), .en_write(wr_b),
    .en_read(rd_b), .clr_err(clr_b), .data_out(dout_b), .data_valid(dv_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(cnt_b), .overflow(ovf_b),
    .underflow(udf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
    tick();
    rst_a = 1'b1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    tick(); tick();
    rst_a = 1'b1; rst_b = 1'b1;
    total++; if (cnt_a !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty_a); end
    total++; if (full_a !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full_a); end
    total++; if (ae_a !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", ae_a); end
    total++; if (af_a !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", af_a); end
    total++; if (dout_a !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout_a); end
    total++; if (dv_a !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", dv_a); end
    total++; if ({ovf_a, udf_a} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {ovf_a, udf_a}); end
    total++; if ({empty_b, ae_b, cnt_b} !== 5'b11000) begin bad++; $display("FAIL reset_b got=%b exp=11000", {empty_b, ae_b, cnt_b}); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      din_a = 8'(i + 1); wr_a = 1'b1;
      tick();
      total++; if (cnt_a !== 5'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, cnt_a, i + 1); end
      total++; if (af_a !== (i + 1 >= 14)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, af_a, (i + 1 >= 14)); end
    end
    wr_a = 1'b0;
    total++; if (full_a !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL fill_ovf got=%b exp=0", ovf_a); end
    for (int i = 0; i < 16; i++) begin
      rd_a = 1'b1;
      tick();
      total++; if (dv_a !== 1'b1) begin bad++; $display("FAIL drain_dv[%0d] got=%b exp=1", i, dv_a); end
      total++; if (dout_a !== 8'(i + 1)) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, dout_a, 8'(i + 1)); end
    end
    rd_a = 1'b0;
    tick();
    total++; if (dv_a !== 1'b0) begin bad++; $display("FAIL drain_dv_end got=%b exp=0", dv_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty_a); end
    total++; if (dout_a !== 8'h10) begin bad++; $display("FAIL drain_hold got=%h exp=10", dout_a); end
    total++; if (udf_a !== 1'b0) begin bad++; $display("FAIL drain_udf got=%b exp=0", udf_a); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin din_a = 8'(8'hC0 + i); wr_a = 1'b1; tick(); end
    wr_a = 1'b0;
    for (int i = 0; i < 10; i++) begin rd_a = 1'b1; tick(); end
    rd_a = 1'b0;
    total++; if (cnt_a !== 5'd0) begin bad++; $display("FAIL wrap_pre_count got=%0d exp=0", cnt_a); end
    for (int i = 0; i < 12; i++) begin din_a = 8'(8'hA0 + i); wr_a = 1'b1; tick(); end
    wr_a = 1'b0;
    total++; if (cnt_a !== 5'd12) begin bad++; $display("FAIL wrap_count got=%0d exp=12", cnt_a); end
    for (int i = 0; i < 12; i++) begin
      rd_a = 1'b1;
      tick();
      total++; if (dout_a !== 8'(8'hA0 + i) || dv_a !== 1'b1) begin bad++; $display("FAIL wrap_data[%0d] got=%h/%b exp=%h/1", i, dout_a, dv_a, 8'(8'hA0 + i)); end
    end
    rd_a = 1'b0;
    total++; if (cnt_a !== 5'd0 || empty_a !== 1'b1) begin bad++; $display("FAIL wrap_end got=%0d/%b exp=0/1", cnt_a, empty_a); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) begin din_a = 8'(8'h30 + i); wr_a = 1'b1; tick(); end
    din_a = 8'h55; wr_a = 1'b1; rd_a = 1'b1;
    tick();
    wr_a = 1'b0;
    total++; if (cnt_a !== 5'd16) begin bad++; $display("FAIL simfull_count got=%0d exp=16", cnt_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL simfull_ovf got=%b exp=0", ovf_a); end
    total++; if (dout_a !== 8'h30 || dv_a !== 1'b1) begin bad++; $display("FAIL simfull_first got=%h/%b exp=30/1", dout_a, dv_a); end
    for (int i = 1; i < 16; i++) begin
      tick();
      total++; if (dout_a !== 8'(8'h30 + i)) begin bad++; $display("FAIL simfull_data[%0d] got=%h exp=%h", i, dout_a, 8'(8'h30 + i)); end
    end
    tick();
    rd_a = 1'b0;
    total++; if (dout_a !== 8'h55 || dv_a !== 1'b1) begin bad++; $display("FAIL simfull_last got=%h/%b exp=55/1", dout_a, dv_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL simfull_empty got=%b exp=1", empty_a); end
  endtask

  task automatic test_simul_empty();
    din_a = 8'h77; wr_a = 1'b1; rd_a = 1'b1;
    tick();
    wr_a = 1'b0; rd_a = 1'b0;
    total++; if (cnt_a !== 5'd1) begin bad++; $display("FAIL simempty_count got=%0d exp=1", cnt_a); end
    total++; if (udf_a !== 1'b1) begin bad++; $display("FAIL simempty_udf got=%b exp=1", udf_a); end
    total++; if (dv_a !== 1'b0) begin bad++; $display("FAIL simempty_dv got=%b exp=0", dv_a); end
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    total++; if (udf_a !== 1'b0) begin bad++; $display("FAIL simempty_clr got=%b exp=0", udf_a); end
    rd_a = 1'b1;
    tick();
    rd_a = 1'b0;
    total++; if (dout_a !== 8'h77 || dv_a !== 1'b1) begin bad++; $display("FAIL simempty_read got=%h/%b exp=77/1", dout_a, dv_a); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 16; i++) begin din_a = 8'(i); wr_a = 1'b1; tick(); end
    din_a = 8'hFF;
    tick();
    wr_a = 1'b0;
    total++; if (ovf_a !== 1'b1 || cnt_a !== 5'd16) begin bad++; $display("FAIL err_ovf got=%b/%0d exp=1/16", ovf_a, cnt_a); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL err_sticky[%0d] got=%b exp=1", i, ovf_a); end
    end
    clr_a = 1'b1;
    tick();
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", ovf_a); end
    wr_a = 1'b1;
    tick();
    wr_a = 1'b0; clr_a = 1'b0;
    total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL err_setwins got=%b exp=1", ovf_a); end
    total++; if (udf_a !== 1'b0) begin bad++; $display("FAIL err_udf got=%b exp=0", udf_a); end
    reset_a();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin din_a = 8'(8'h60 + i); wr_a = 1'b1; tick(); end
    total++; if (cnt_a !== 5'd7) begin bad++; $display("FAIL rmid_pre got=%0d exp=7", cnt_a); end
    din_a = 8'hEE; rst_a = 1'b0;
    tick();
    rst_a = 1'b1; wr_a = 1'b0;
    total++; if (cnt_a !== 5'd0 || empty_a !== 1'b1) begin bad++; $display("FAIL rmid_count got=%0d/%b exp=0/1", cnt_a, empty_a); end
    total++; if (dout_a !== 8'h00) begin bad++; $display("FAIL rmid_dout got=%h exp=00", dout_a); end
    rd_a = 1'b1;
    tick();
    rd_a = 1'b0;
    total++; if (udf_a !== 1'b1 || dv_a !== 1'b0) begin bad++; $display("FAIL rmid_udf got=%b/%b exp=1/0", udf_a, dv_a); end
    total++; if (cnt_a !== 5'd0) begin bad++; $display("FAIL rmid_discard got=%0d exp=0", cnt_a); end
  endtask

  task automatic test_param_sweep();
    for (int i = 0; i < 4; i++) begin
      din_b = 32'hDEAD0000 + 32'(i); wr_b = 1'b1;
      tick();
      total++; if (cnt_b !== 3'(i + 1)) begin bad++; $display("FAIL b_count[%0d] got=%0d exp=%0d", i, cnt_b, i + 1); end
      total++; if ({af_b, ae_b} !== {(i + 1 >= 3), (i + 1 <= 1)}) begin bad++; $display("FAIL b_flags[%0d] got=%b%b exp=%b%b", i, af_b, ae_b, (i + 1 >= 3), (i + 1 <= 1)); end
    end
    total++; if (full_b !== 1'b1) begin bad++; $display("FAIL b_full got=%b exp=1", full_b); end
    din_b = 32'hBADBAD00;
    tick();
    wr_b = 1'b0;
    total++; if (ovf_b !== 1'b1 || cnt_b !== 3'd4) begin bad++; $display("FAIL b_ovf got=%b/%0d exp=1/4", ovf_b, cnt_b); end
    for (int i = 0; i < 4; i++) begin
      rd_b = 1'b1;
      tick();
      total++; if (dout_b !== 32'hDEAD0000 + 32'(i) || dv_b !== 1'b1) begin bad++; $display("FAIL b_data[%0d] got=%h/%b exp=%h/1", i, dout_b, dv_b, 32'hDEAD0000 + 32'(i)); end
    end
    rd_b = 1'b0;
    total++; if (empty_b !== 1'b1 || udf_b !== 1'b0) begin bad++; $display("FAIL b_end got=%b/%b exp=1/0", empty_b, udf_b); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul_full();
    test_simul_empty();
    reset_a();
    test_errors();
    test_reset_mid();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
